// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester round-robin front end for one shared 8-bit ALU.
// A request is granted in IDLE, its operands are registered onto the ALU bus with
// a one-cycle alu_issue pulse, the result/flags are captured ALU_LAT cycles later
// and held on the granted response channel until that requester accepts.
// Optional build macro ALU_CMD_CHECK_EN: illegal commands are accepted but answered
// locally with an error flag instead of being issued to the ALU.
module alu_share_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [1:0]  req_mode,
  input  logic [7:0]  req_cmd,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  rsp_res,
  output logic [7:0]  rsp_flag,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_mode,
  output logic [3:0]  alu_cmd,
  output logic        alu_issue,
  input  logic [7:0]  alu_res,
  input  logic [7:0]  alu_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        ptr;        // round-robin priority pointer
  logic        gnt;        // requester owning the in-flight operation
  logic [2:0]  cnt;        // remaining ALU latency cycles
  logic        sel;        // grant candidate this cycle
  logic        any_req;
  logic        hs;         // request handshake in IDLE
  logic        illegal;    // granted command must not reach the ALU
  logic        cnt_last;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic        sel_mode;
  logic [3:0]  sel_cmd;

  // Grant candidate: the pointed-to requester wins, otherwise the other one.
  always_comb begin
    sel      = req_valid[ptr] ? ptr : ~ptr;
    any_req  = |req_valid;
    hs       = (state == IDLE) && any_req;
    sel_a    = sel ? req_a[15:8]  : req_a[7:0];
    sel_b    = sel ? req_b[15:8]  : req_b[7:0];
    sel_mode = sel ? req_mode[1]  : req_mode[0];
    sel_cmd  = sel ? req_cmd[7:4] : req_cmd[3:0];
    cnt_last = (cnt == 3'd1);
  end

`ifdef ALU_CMD_CHECK_EN
  // Command legality: arithmetic accepts 0..6, logical accepts 0..8.
  always_comb begin
    illegal = sel_mode ? (sel_cmd > 4'd6) : (sel_cmd > 4'd8);
  end
`else
  // Every command is forwarded; the ALU reports errors through its flags.
  always_comb begin
    illegal = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt = illegal ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_last) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[gnt]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if ((state == IDLE) && any_req) begin
      req_ready[sel] = 1'b1;
    end
    if (state == RESP) begin
      rsp_valid[gnt] = 1'b1;
    end
  end

  // Datapath: ALU bus registers, latency counter, response capture, pointer.
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_mode  <= 1'b0;
      alu_cmd   <= '0;
      alu_issue <= 1'b0;
      rsp_res   <= '0;
      rsp_flag  <= '0;
    end else begin
      alu_issue <= hs && !illegal;
      case (state)
        IDLE: begin
          if (hs) begin
            gnt <= sel;
            cnt <= 3'(ALU_LAT);
            if (illegal) begin
              rsp_res  <= '0;
              rsp_flag <= sel_mode ? 8'h80 : 8'h40;
            end else begin
              alu_a    <= sel_a;
              alu_b    <= sel_b;
              alu_mode <= sel_mode;
              alu_cmd  <= sel_cmd;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt_last) begin
            rsp_res  <= alu_res;
            rsp_flag <= alu_flag;
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            ptr <= ~gnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: one instance at ALU_LAT=1 and one at
// ALU_LAT=4, each with its own behavioural ALU that presents a valid result only
// on the cycle the arbiter should capture it. Unused instance is held in reset.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic        sel = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [1:0]  req_mode = '0;
  logic [7:0]  req_cmd = '0;
  logic [1:0]  rsp_ready = 2'b11;

  logic [1:0]  d1_req_ready, d1_rsp_valid, d4_req_ready, d4_rsp_valid;
  logic [7:0]  d1_rsp_res, d1_rsp_flag, d1_alu_a, d1_alu_b, d1_alu_res, d1_alu_flag;
  logic [7:0]  d4_rsp_res, d4_rsp_flag, d4_alu_a, d4_alu_b, d4_alu_res, d4_alu_flag;
  logic        d1_alu_mode, d1_alu_issue, d4_alu_mode, d4_alu_issue;
  logic [3:0]  d1_alu_cmd, d4_alu_cmd;

  logic [1:0]  c_req_ready, c_rsp_valid;
  logic [7:0]  c_rsp_res, c_rsp_flag, c_alu_a, c_alu_b;
  logic        c_alu_mode, c_alu_issue;
  logic [3:0]  c_alu_cmd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.ALU_LAT(1)) u_dut1 (
    .clk(clk), .RST(rst1), .req_valid(req_valid), .req_ready(d1_req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_cmd(req_cmd),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_res(d1_rsp_res),
    .rsp_flag(d1_rsp_flag), .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_mode(d1_alu_mode),
    .alu_cmd(d1_alu_cmd), .alu_issue(d1_alu_issue), .alu_res(d1_alu_res), .alu_flag(d1_alu_flag)
  );

  alu_share_arbiter #(.ALU_LAT(4)) u_dut4 (
    .clk(clk), .RST(rst4), .req_valid(req_valid), .req_ready(d4_req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_cmd(req_cmd),
    .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_res(d4_rsp_res),
    .rsp_flag(d4_rsp_flag), .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_mode(d4_alu_mode),
    .alu_cmd(d4_alu_cmd), .alu_issue(d4_alu_issue), .alu_res(d4_alu_res), .alu_flag(d4_alu_flag)
  );

  // Reference ALU: returns {flag, res}; flag = {6'b0, zero, carry/borrow}.
  function automatic logic [15:0] alu_f(logic [7:0] a, logic [7:0] b, logic mode, logic [3:0] cmd);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    if (mode) begin
      case (cmd)
        4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
        4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; end
        default: r = a;
      endcase
    end else begin
      case (cmd)
        4'd0: r = a & b;
        4'd1: r = a | b;
        4'd2: r = a ^ b;
        default: r = ~a;
      endcase
    end
    return {6'b0, (r == 8'h00), c, r};
  endfunction

  // Cycles since the last alu_issue cycle, per instance.
  int unsigned age1 = 100, age4 = 100;
  always @(posedge clk) begin
    age1 <= d1_alu_issue ? 1 : ((age1 < 100) ? age1 + 1 : age1);
    age4 <= d4_alu_issue ? 1 : ((age4 < 100) ? age4 + 1 : age4);
  end

  // Result is valid only LAT-1 cycles after the issue cycle; garbage otherwise.
  always_comb begin
    {d1_alu_flag, d1_alu_res} = 16'hEEEE;
    {d4_alu_flag, d4_alu_res} = 16'hEEEE;
    if (d1_alu_issue) {d1_alu_flag, d1_alu_res} = alu_f(d1_alu_a, d1_alu_b, d1_alu_mode, d1_alu_cmd);
    if (!d4_alu_issue && age4 == 3) {d4_alu_flag, d4_alu_res} = alu_f(d4_alu_a, d4_alu_b, d4_alu_mode, d4_alu_cmd);
  end

  always_comb begin
    c_req_ready = sel ? d4_req_ready : d1_req_ready;
    c_rsp_valid = sel ? d4_rsp_valid : d1_rsp_valid;
    c_rsp_res   = sel ? d4_rsp_res   : d1_rsp_res;
    c_rsp_flag  = sel ? d4_rsp_flag  : d1_rsp_flag;
    c_alu_a     = sel ? d4_alu_a     : d1_alu_a;
    c_alu_b     = sel ? d4_alu_b     : d1_alu_b;
    c_alu_mode  = sel ? d4_alu_mode  : d1_alu_mode;
    c_alu_cmd   = sel ? d4_alu_cmd   : d1_alu_cmd;
    c_alu_issue = sel ? d4_alu_issue : d1_alu_issue;
  end

  function automatic logic [1:0] oh(int g);
    return (g != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic cmd_illegal(logic mode, logic [3:0] cmd);
`ifdef ALU_CMD_CHECK_EN
    return mode ? (cmd > 4'd6) : (cmd > 4'd8);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 2'b11; rst1 = 1'b1; rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst1 = sel; rst4 = !sel;
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [15:0] a, b;
    logic [1:0]  mode;
    logic [7:0]  cmd;
    int          g;
    logic [7:0]  res, flag;
  } vec_t;

  // One transaction: wait for accept, check grant, issue timing and response.
  task automatic do_txn(input vec_t v, input string nm);
    logic got;
    int lat;
    lat = sel ? 4 : 1;
    @(posedge clk); #1;
    req_valid = v.rv; req_a = v.a; req_b = v.b; req_mode = v.mode; req_cmd = v.cmd;
    rsp_ready = 2'b11;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (|(c_req_ready & req_valid)) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk({nm, "_accept"}, 32'(got), 32'd1);
    chk({nm, "_grant"}, 32'(c_req_ready), 32'(oh(v.g)));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk({nm, "_issue"}, 32'(c_alu_issue), 32'd1);
    chk({nm, "_alu_a"}, 32'(c_alu_a), 32'((v.g != 0) ? v.a[15:8] : v.a[7:0]));
    chk({nm, "_alu_cmd"}, 32'(c_alu_cmd), 32'((v.g != 0) ? v.cmd[7:4] : v.cmd[3:0]));
    chk({nm, "_no_early_rsp"}, 32'(c_rsp_valid), 32'd0);
    repeat (lat) @(negedge clk);
    chk({nm, "_rsp_valid"}, 32'(c_rsp_valid), 32'(oh(v.g)));
    chk({nm, "_rsp_res"}, 32'(c_rsp_res), 32'(v.res));
    chk({nm, "_rsp_flag"}, 32'(c_rsp_flag), 32'(v.flag));
  endtask

  task automatic wait_accept(input string nm);
    logic got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (|(c_req_ready & req_valid)) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk({nm, "_accept"}, 32'(got), 32'd1);
  endtask

  // Randomized traffic against a transaction-level model of the arbiter.
  task automatic run_random(input int n, input string nm);
    int lat, cyc, m_done, m_iss, g;
    logic m_busy, m_ptr, m_g, m_mode;
    logic [7:0] m_res, m_flag, m_a;
    logic [3:0] m_cmd;
    logic [1:0] exp_rr, exp_rv;
    logic [15:0] fr;
    lat = sel ? 4 : 1;
    m_busy = 0; m_ptr = 0; m_g = 0; m_done = 0; m_iss = -1; cyc = 0;
    m_res = 0; m_flag = 0; m_a = 0; m_cmd = 0; m_mode = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      req_valid = 2'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
      req_mode = 2'($urandom); req_cmd = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0) ? 2'($urandom) | 2'b01 : 2'($urandom);
      @(negedge clk);
      exp_rr = '0; g = 0;
      if (!m_busy && (req_valid != 2'b00)) begin
        g = req_valid[m_ptr] ? int'(m_ptr) : int'(!m_ptr);
        exp_rr = oh(g);
      end
      exp_rv = (m_busy && cyc >= m_done) ? oh(int'(m_g)) : 2'b00;
      chk({nm, "_req_ready"}, 32'(c_req_ready), 32'(exp_rr));
      chk({nm, "_rsp_valid"}, 32'(c_rsp_valid), 32'(exp_rv));
      chk({nm, "_issue"}, 32'(c_alu_issue), 32'(cyc == m_iss));
      if (cyc == m_iss) begin
        chk({nm, "_alu_a"}, 32'(c_alu_a), 32'(m_a));
        chk({nm, "_alu_cmd"}, 32'({m_mode, c_alu_cmd} == {m_mode, m_cmd} && c_alu_mode == m_mode), 32'd1);
      end
      if (exp_rv != 2'b00) begin
        chk({nm, "_rsp_res"}, 32'(c_rsp_res), 32'(m_res));
        chk({nm, "_rsp_flag"}, 32'(c_rsp_flag), 32'(m_flag));
        if (rsp_ready[m_g]) begin
          m_busy = 0; m_ptr = !m_g;
        end
      end else if (exp_rr != 2'b00) begin
        m_busy = 1; m_g = (g != 0);
        m_a = m_g ? req_a[15:8] : req_a[7:0];
        m_mode = req_mode[m_g];
        m_cmd = m_g ? req_cmd[7:4] : req_cmd[3:0];
        if (cmd_illegal(m_mode, m_cmd)) begin
          m_done = cyc + 1; m_res = 8'h00; m_flag = m_mode ? 8'h80 : 8'h40;
        end else begin
          fr = alu_f(m_a, m_g ? req_b[15:8] : req_b[7:0], m_mode, m_cmd);
          m_res = fr[7:0]; m_flag = fr[15:8];
          m_done = cyc + lat + 1; m_iss = cyc + 1;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 2'b11;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int issues[$];
    int grants[$];
    int cyc, nrsp;
    logic [7:0] held;

    vecs[0] = '{2'b01, 16'h0080, 16'h0090, 2'b01, 8'h00, 0, 8'h10, 8'h01};
    vecs[1] = '{2'b10, 16'hF000, 16'h3C00, 2'b00, 8'h00, 1, 8'h30, 8'h00};
    vecs[2] = '{2'b11, 16'hF005, 16'h3C05, 2'b01, 8'h01, 0, 8'h00, 8'h02};
    vecs[3] = '{2'b11, 16'hF005, 16'h3C05, 2'b01, 8'h01, 1, 8'h30, 8'h00};
    vecs[4] = '{2'b11, 16'hF005, 16'h3C05, 2'b01, 8'h01, 0, 8'h00, 8'h02};
    vecs[5] = '{2'b10, 16'hAA00, 16'h5500, 2'b00, 8'h20, 1, 8'hFF, 8'h00};
    vecs[6] = '{2'b01, 16'h000F, 16'h00F0, 2'b00, 8'h01, 0, 8'hFF, 8'h00};
    vecs[7] = '{2'b10, 16'h1000, 16'h2000, 2'b10, 8'h10, 1, 8'hF0, 8'h01};

    rst1 = 1'b1; rst4 = 1'b1;
    sel = 1'b0;
    do_reset();

    // Reset state with no requests.
    @(negedge clk);
    chk("rst_req_ready", 32'(c_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(c_rsp_valid), 32'd0);
    chk("rst_rsp_res", 32'(c_rsp_res), 32'd0);
    chk("rst_rsp_flag", 32'(c_rsp_flag), 32'd0);
    chk("rst_alu_bus", 32'({c_alu_a, c_alu_b, c_alu_mode, c_alu_cmd, c_alu_issue}), 32'd0);

    // Table-driven transactions at ALU_LAT=1.
    foreach (vecs[i]) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back contention from reset: grants alternate, issue spacing 3.
    do_reset();
    req_valid = 2'b11; req_a = 16'hF005; req_b = 16'hF005 & 16'hFFFF;
    req_b = 16'h3C05; req_mode = 2'b01; req_cmd = 8'h01; rsp_ready = 2'b11;
    cyc = 0;
    for (int k = 0; k < 40 && grants.size() < 4; k++) begin
      @(negedge clk);
      cyc++;
      if (c_alu_issue) issues.push_back(cyc);
      if (c_rsp_valid == 2'b01) grants.push_back(0);
      if (c_rsp_valid == 2'b10) begin
        grants.push_back(1);
        chk("cont_req1_res", 32'(c_rsp_res), 32'h30);
      end
    end
    chk("cont_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size(); k++) chk($sformatf("cont_grant%0d", k), 32'(grants[k]), 32'(k % 2));
    for (int k = 1; k < issues.size(); k++) chk($sformatf("cont_spacing%0d", k), 32'(issues[k] - issues[k-1]), 32'd3);
    @(posedge clk); #1;
    req_valid = '0;

    // Response backpressure: 5 stalled cycles, accept on the 6th.
    do_reset();
    req_valid = 2'b01; req_a = 16'h0080; req_b = 16'h0090; req_mode = 2'b01; req_cmd = 8'h00;
    rsp_ready = 2'b00;
    wait_accept("bp");
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(c_rsp_valid), 32'h1);
      chk("bp_rsp_res", 32'(c_rsp_res), 32'h10);
      chk("bp_req_ready", 32'(c_req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_accept_valid", 32'(c_rsp_valid), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_valid", 32'(c_rsp_valid), 32'h0);
    chk("bp_idle_ready", 32'(c_req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 2'b11;

    // Reset mid-WAIT at ALU_LAT=4.
    sel = 1'b1;
    do_reset();
    do_txn(vecs[0], "lat4");
    @(posedge clk); #1;
    req_valid = 2'b10; req_a = 16'hF000; req_b = 16'h3C00; req_mode = 2'b00; req_cmd = 8'h00;
    wait_accept("mid");
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_issue", 32'(c_alu_issue), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    @(negedge clk);
    chk("mid_alu_bus", 32'({c_alu_a, c_alu_b, c_alu_mode, c_alu_cmd, c_alu_issue}), 32'd0);
    chk("mid_rsp_regs", 32'({c_rsp_res, c_rsp_flag}), 32'd0);
    nrsp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (c_rsp_valid != 2'b00) nrsp++;
    end
    chk("mid_no_rsp", 32'(nrsp), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("mid_next_grant", 32'(c_req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;

    // Illegal command handling at ALU_LAT=1.
    sel = 1'b0;
    do_reset();
    req_valid = 2'b01; req_a = 16'h0033; req_b = 16'h0011; req_mode = 2'b01; req_cmd = 8'h0A;
    wait_accept("ill");
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
`ifdef ALU_CMD_CHECK_EN
    chk("ill_issue", 32'(c_alu_issue), 32'd0);
    chk("ill_alu_cmd", 32'(c_alu_cmd), 32'd0);
    chk("ill_rsp_valid", 32'(c_rsp_valid), 32'h1);
    chk("ill_rsp", 32'({c_rsp_res, c_rsp_flag}), 32'h0080);
`else
    chk("ill_issue", 32'(c_alu_issue), 32'd1);
    chk("ill_alu_cmd", 32'(c_alu_cmd), 32'hA);
    @(negedge clk);
    chk("ill_rsp_valid", 32'(c_rsp_valid), 32'h1);
    chk("ill_rsp", 32'({c_rsp_res, c_rsp_flag}), 32'h3300);
`endif
    held = c_rsp_res;

    // Randomized runs at both latencies.
    sel = 1'b0;
    do_reset();
    run_random(400, "rnd1");
    sel = 1'b1;
    do_reset();
    run_random(400, "rnd4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 8-bit ALU between two requesters using per-requester valid/ready request and response channels with round-robin grant. Registers the winning operands, mode and command onto the ALU input bus, waits a fixed ALU result latency, then captures result and flags. Returns them to the granted requester and holds them until that requester accepts. Sits between the two client blocks and the ALU instance.

Parameters:
ALU_LAT, 1, cycles from alu_issue high to alu_res/alu_flag valid; legal range 1..7.

Ports:
clk  in  1  clock, all logic rising-edge
RST  in  1  synchronous active-high reset
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accept, at most one bit high
req_a  in  16  operand A, [8i+7:8i] = requester i
req_b  in  16  operand B, same packing
req_mode  in  2  1 = arithmetic, 0 = logical, per requester
req_cmd  in  8  4-bit command, [4i+3:4i] = requester i
rsp_valid  out  2  response valid, at most one bit high
rsp_ready  in  2  response accept, per requester
rsp_res  out  8  captured result, shared by both requesters
rsp_flag  out  8  captured flags, shared by both requesters
alu_a  out  8  ALU operand A, registered
alu_b  out  8  ALU operand B, registered
alu_mode  out  1  ALU mode, registered
alu_cmd  out  4  ALU command, registered
alu_issue  out  1  one-cycle pulse, ALU inputs newly valid
alu_res  in  8  ALU result
alu_flag  in  8  ALU flags

Behaviour:
- Clock is clk; reset is RST, synchronous, active-high.
- Reset values: state IDLE, priority pointer ptr=0, req_ready=0, rsp_valid=0, rsp_res=0, rsp_flag=0, alu_a=0, alu_b=0, alu_mode=0, alu_cmd=0, alu_issue=0.
- States: IDLE, WAIT, RESP.
- IDLE, grant selection:
  - grant g = ptr if req_valid[ptr], else ~ptr if req_valid[~ptr].
  - req_ready[g] is high combinationally in IDLE only, and only when some req_valid is high.
  - Handshake is req_valid[g] & req_ready[g].
- IDLE, on handshake:
  - Register the g operand slice into alu_a/alu_b/alu_mode/alu_cmd.
  - Set alu_issue=1 for the next cycle; latch g; load cnt=ALU_LAT; go to WAIT.
- WAIT:
  - req_ready=0.
  - cnt decrements each cycle; when cnt==1, capture alu_res into rsp_res and alu_flag into rsp_flag, then go to RESP.
  - Capture edge is exactly ALU_LAT cycles after the alu_issue cycle.
- RESP:
  - rsp_valid[g]=1; rsp_res/rsp_flag held stable.
  - On rsp_ready[g]: rsp_valid=0, ptr=~g, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- alu_* outputs hold their last values between operations and change only on an IDLE handshake.
- Minimum issue-to-issue spacing is ALU_LAT+2 cycles, with rsp_ready held high.
- Simultaneous req_valid on both requesters: ptr decides. Back-to-back contention alternates 0,1,0,1.
- A requester dropping req_valid before handshake is legal; no grant is recorded.
- A new request can only be accepted on the cycle after a response is accepted, because IDLE is re-entered first.
- Flags pass through unmodified; this block does not interpret ALU flag bits.
- RST mid-operation (WAIT or RESP): in-flight operation discarded, no response issued, all outputs to reset values next cycle.

Optional Feature:
ALU_CMD_CHECK_EN
- Defined:
  - In IDLE, a granted request with an illegal command is still accepted (req_ready as normal) but not issued to the ALU.
  - Illegal = arithmetic cmd>6, or logical cmd>8.
  - No alu_issue pulse; alu_* unchanged; state goes directly to RESP next cycle.
  - rsp_res=0; rsp_flag=8'h80 for arithmetic, 8'h40 for logical.
  - ptr update as normal.
- Undefined: all commands are issued to the ALU unchanged; errors are reported only through alu_flag.

Test Plan:
- Reset then idle: RST high 2 cycles -> all outputs 0, req_ready=0 while req_valid=0.
- Single arithmetic add, ALU_LAT=1, bench ALU model: req0 A=8'h80 B=8'h90 mode=1 cmd=0 -> alu_issue 1 cycle after accept; rsp_valid[0] 2 cycles after accept; rsp_res=8'h10, rsp_flag[0]=1.
- Contention: both valid from reset, req1 logical AND A=8'hF0 B=8'h3C -> grants 0,1,0,1; req1 response 8'h30; issue-to-issue spacing 3 cycles with rsp_ready=1.
- Response backpressure: rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_res stable, req_ready stays 0; accept on the 6th cycle -> IDLE next cycle.
- Reset mid-WAIT, ALU_LAT=4: RST asserted 2 cycles after issue -> no rsp_valid ever, ptr=0, next grant goes to req0.
- With ALU_CMD_CHECK_EN: req0 mode=1 cmd=4'hA -> no alu_issue, rsp_flag=8'h80 one cycle after accept. Without it: alu_issue pulses and alu_cmd=4'hA.
